wb_daq_sram_arbiter: RTL and testbench
======================================

// Module: wb_daq_sram_arbiter
// PURPOSE
//  Shares one SRAM write port between NUM_CHANNELS DAQ channels.
//  Each channel requests with start_sram and holds a 32-bit aggregated word on channel_data.
//  The block grants channels round-robin, writes one word per grant into that channel's
//  private ring region of SRAM, and acknowledges the channel with a data_done pulse.
//  It sits between the per-channel FIFO-to-SRAM movers and the SRAM controller.
// PARAMETERS
//  NUM_CHANNELS  4    number of requesting channels (>=2)
//  dw            32   data word width
//  aw            16   SRAM word address width; must be >= clog2(NUM_CHANNELS*REGION_WORDS)
//  REGION_WORDS  1024 words per channel ring region; power of two
// PORTS
//  wb_clk         in   1                 single clock, all logic rising-edge
//  wb_rst         in   1                 reset, asynchronous, active-high
//  master_enable  in   1                 global enable; low blocks new grants only
//  channel_enable in   NUM_CHANNELS      per-channel enable (control[0] of each channel)
//  pointer_clear  in   1                 sync clear of all ring write pointers
//  start_sram     in   NUM_CHANNELS      request level; held high until matching data_done
//  channel_data   in   NUM_CHANNELS*dw   channel i word at [i*dw +: dw]
//  sram_ack       in   1                 SRAM write accepted (any number of wait cycles)
//  data_done      out  NUM_CHANNELS      one-cycle acknowledge per written word
//  grant          out  NUM_CHANNELS      one-hot owner of SRAM port; 0 when idle
//  sram_we        out  1                 write strobe
//  sram_addr      out  aw                write address
//  sram_data      out  dw                write data
//  wrap_pulse     out  NUM_CHANNELS      one-cycle pulse when a channel pointer wraps to 0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; all pointers 0; round-robin last = NUM_CHANNELS-1.
//  All outputs are registered.
//  FSM states: IDLE, WRITE, DONE.
//  IDLE: eligible = start_sram & channel_enable, qualified by master_enable.
//   If eligible != 0, pick the first set bit searching from last+1 upward, modulo NUM_CHANNELS.
//   Next cycle: grant one-hot, sram_we=1.
//   sram_addr = ch*REGION_WORDS + ptr[ch]; sram_data = channel_data[ch] captured in that cycle.
//   last <= ch. Go to WRITE.
//  WRITE: sram_we/addr/data/grant held stable until sram_ack is sampled high.
//   On ack, next cycle: sram_we=0, grant=0, data_done[ch]=1.
//   ptr[ch] increments mod REGION_WORDS; wrap_pulse[ch]=1 if it went REGION_WORDS-1 -> 0.
//   Go to DONE.
//  DONE: one idle cycle so the channel can drop start_sram; then IDLE.
//  Latency: request seen in IDLE cycle N -> sram_we high N+1.
//   Ack sampled cycle M -> data_done high M+1 -> IDLE M+2.
//   Next sram_we at M+3 at the earliest.
//  Mid-operation events:
//   - channel_enable, start_sram or master_enable dropping during WRITE does not abort;
//     the word completes and data_done is still pulsed.
//   - sram_ack outside WRITE is ignored.
//  pointer_clear: zeroes all pointers next cycle and wins over an increment in the same
//   cycle. A word in flight keeps its already-registered address.
//  Simultaneous requests are served strictly round-robin; no channel is granted twice
//   while another eligible channel waits.
//  wb_rst mid-WRITE: sram_we, grant and data_done drop immediately (asynchronous).
//   The word is lost; the channel re-requests after reset.
// TESTING
//  1. Single request, 0-wait ack:
//     ch1 start_sram, data 0xA5A5_0001, sram_ack tied 1 -> sram_we 1 cycle at addr 1024;
//     data_done[1] next cycle; ptr1=1.
//  2. All 4 channels requesting continuously -> grants in order 0,1,2,3,0,...
//     Each channel's address increments inside its own region.
//  3. sram_ack delayed 5 cycles -> sram_we/addr/data held 6 cycles;
//     exactly one data_done, one cycle wide.
//  4. ch0 ptr at 1023, one write -> addr 1023, wrap_pulse[0]=1, next ch0 write at addr 0.
//  5. master_enable drops during WRITE -> current word completes;
//     no new grant while low; resumes when high.
//  6. wb_rst asserted mid-WRITE -> outputs 0 within the same cycle; after release,
//     all pointers 0 and the first grant goes to ch0.

Source files
------------

// File: rtl/wb_daq_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM write port between DAQ channels.
// Each grant writes one word into the channel's private ring region and acknowledges it.
module wb_daq_sram_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int dw           = 32,
  parameter int aw           = 16,
  parameter int REGION_WORDS = 1024
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic                       master_enable,
  input  logic [NUM_CHANNELS-1:0]    channel_enable,
  input  logic                       pointer_clear,
  input  logic [NUM_CHANNELS-1:0]    start_sram,
  input  logic [NUM_CHANNELS*dw-1:0] channel_data,
  input  logic                       sram_ack,
  output logic [NUM_CHANNELS-1:0]    data_done,
  output logic [NUM_CHANNELS-1:0]    grant,
  output logic                       sram_we,
  output logic [aw-1:0]              sram_addr,
  output logic [dw-1:0]              sram_data,
  output logic [NUM_CHANNELS-1:0]    wrap_pulse
);

  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int PW = $clog2(REGION_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           last, last_next, cur, cur_next;
  logic [PW-1:0]           ptr [NUM_CHANNELS];
  logic [dw-1:0]           ch_word [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] eligible;
  logic [CW-1:0]           pick, idx;
  logic                    found, ptr_inc;

  logic [NUM_CHANNELS-1:0] grant_next, done_next, wrap_next;
  logic                    we_next;
  logic [aw-1:0]           addr_next;
  logic [dw-1:0]           data_next;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
    assign ch_word[g] = channel_data[g*dw +: dw];
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    eligible = start_sram & channel_enable & {NUM_CHANNELS{master_enable}};
    pick     = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      idx = CW'((int'(last) + k) % NUM_CHANNELS);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values together.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found)    state_next = WRITE;
      WRITE:   if (sram_ack) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // NOTE: every value is defaulted first, so no path through the case infers a latch.
  always_comb begin
    grant_next = grant;
    we_next    = sram_we;
    addr_next  = sram_addr;
    data_next  = sram_data;
    done_next  = '0;
    wrap_next  = '0;
    last_next  = last;
    cur_next   = cur;
    ptr_inc    = 1'b0;
    case (state)
      IDLE: if (found) begin
        grant_next = NUM_CHANNELS'(1) << pick;
        we_next    = 1'b1;
        addr_next  = aw'({pick, ptr[pick]});
        data_next  = ch_word[pick];
        last_next  = pick;
        cur_next   = pick;
      end
      WRITE: if (sram_ack) begin
        grant_next     = '0;
        we_next        = 1'b0;
        done_next[cur] = 1'b1;
        wrap_next[cur] = &ptr[cur];
        ptr_inc        = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the pointer array is a handful of flops, not a RAM, so it is reset with the rest.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      grant      <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_data  <= '0;
      data_done  <= '0;
      wrap_pulse <= '0;
      last       <= CW'(NUM_CHANNELS - 1);
      cur        <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) ptr[i] <= '0;
    end else begin
      grant      <= grant_next;
      sram_we    <= we_next;
      sram_addr  <= addr_next;
      sram_data  <= data_next;
      data_done  <= done_next;
      wrap_pulse <= wrap_next;
      last       <= last_next;
      cur        <= cur_next;
      // Clear wins over the increment; the in-flight address is already registered.
      if (pointer_clear) begin
        for (int i = 0; i < NUM_CHANNELS; i++) ptr[i] <= '0;
      end else if (ptr_inc) begin
        ptr[cur] <= ptr[cur] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_daq_sram_arbiter.sv
// Bench for wb_daq_sram_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_wb_daq_sram_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int RW = 1024;

  logic            wb_clk = 1'b0;
  logic            wb_rst;
  logic            master_enable;
  logic [N-1:0]    channel_enable;
  logic            pointer_clear;
  logic [N-1:0]    start_sram;
  logic [N*DW-1:0] channel_data;
  logic            sram_ack;
  logic [N-1:0]    data_done, grant, wrap_pulse;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_data;

  wb_daq_sram_arbiter #(.NUM_CHANNELS(N), .dw(DW), .aw(AW), .REGION_WORDS(RW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .master_enable(master_enable),
    .channel_enable(channel_enable), .pointer_clear(pointer_clear),
    .start_sram(start_sram), .channel_data(channel_data), .sram_ack(sram_ack),
    .data_done(data_done), .grant(grant), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_data(sram_data), .wrap_pulse(wrap_pulse)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one in-flight write, round-robin pointer, per-channel ring pointers,
  // and a one-cycle gap after each acknowledge before the next grant can be decided.
  int            m_last, m_ch, m_cool;
  int            m_ptr [N];
  bit            m_busy;
  logic [N-1:0]  e_grant, e_done, e_wrap;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    m_last = N - 1; m_ch = 0; m_cool = 0; m_busy = 0;
    for (int i = 0; i < N; i++) m_ptr[i] = 0;
    e_grant = '0; e_done = '0; e_wrap = '0; e_we = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step();
    int c;
    bit found;
    e_done = '0;
    e_wrap = '0;
    if (m_busy) begin
      if (sram_ack) begin
        e_we = 0; e_grant = '0;
        e_done[m_ch] = 1'b1;
        e_wrap[m_ch] = (m_ptr[m_ch] == RW - 1);
        m_ptr[m_ch]  = (m_ptr[m_ch] + 1) % RW;
        m_busy = 0;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (master_enable) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && start_sram[c] && channel_enable[c]) begin
          found   = 1;
          e_we    = 1;
          e_grant = '0;
          e_grant[c] = 1'b1;
          e_addr  = AW'(c * RW + m_ptr[c]);
          e_data  = channel_data[c*DW +: DW];
          m_last  = c;
          m_ch    = c;
          m_busy  = 1;
        end
      end
    end
    if (pointer_clear) for (int i = 0; i < N; i++) m_ptr[i] = 0;
  endtask

  task automatic compare();
    check("grant", grant, e_grant);
    check("sram_we", sram_we, e_we);
    check("data_done", data_done, e_done);
    check("wrap_pulse", wrap_pulse, e_wrap);
    if (e_we) begin
      check("sram_addr", sram_addr, e_addr);
      check("sram_data", sram_data, e_data);
    end
  endtask

  // Inputs are set between negedges; the model predicts the outputs after the next posedge.
  task automatic tick();
    model_step();
    @(negedge wb_clk);
    compare();
  endtask

  int hold [N];

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (data_done[i]) begin
        start_sram[i] = 1'b0;
        hold[i] = $urandom_range(0, 3);
      end else if (!start_sram[i]) begin
        if (hold[i] > 0) hold[i]--;
        else if ($urandom_range(0, 2) == 0) begin
          start_sram[i] = 1'b1;
          channel_data[i*DW +: DW] = $urandom();
        end
      end
      channel_enable[i] = ($urandom_range(0, 9) != 0);
    end
    master_enable = ($urandom_range(0, 7) != 0);
    sram_ack      = ($urandom_range(0, 2) == 0);
    pointer_clear = ($urandom_range(0, 199) == 0);
  endtask

  int n_we, n_done, n0;

  initial begin
    wb_rst = 1'b0;
    master_enable = 1'b0; channel_enable = '0; pointer_clear = 1'b0;
    start_sram = '0; channel_data = '0; sram_ack = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    #1 wb_rst = 1'b1;
    model_reset();
    repeat (2) @(negedge wb_clk);
    compare();
    wb_rst = 1'b0;

    // Single request on ch1 with zero-wait acknowledge.
    master_enable = 1'b1; channel_enable = '1; sram_ack = 1'b1;
    start_sram = 4'b0010;
    channel_data[1*DW +: DW] = 32'hA5A5_0001;
    tick();
    check("t1_addr", sram_addr, 16'd1024);
    check("t1_data", sram_data, 32'hA5A5_0001);
    tick();
    check("t1_done", data_done, 4'b0010);
    start_sram = '0;
    repeat (2) tick();

    // Acknowledge delayed five cycles: write held six cycles, one done pulse.
    sram_ack = 1'b0; start_sram = 4'b0100;
    channel_data[2*DW +: DW] = $urandom();
    n_we = 0; n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) sram_ack = 1'b1;
      tick();
      n_we   += int'(sram_we);
      n_done += int'(data_done[2]);
      if (data_done[2]) start_sram = '0;
    end
    check("t3_we_cycles", n_we, 6);
    check("t3_done_count", n_done, 1);

    // Fill ch0's ring until its pointer wraps, then check the wrapped address.
    start_sram = 4'b0001; sram_ack = 1'b1; n0 = 0;
    for (int i = 0; i < 3300 && n0 < 1025; i++) begin
      channel_data[0 +: DW] = $urandom();
      tick();
      if (sram_we && n0 == 1023) check("t4_addr_last", sram_addr, 16'd1023);
      if (sram_we && n0 == 1024) check("t4_addr_zero", sram_addr, 16'd0);
      if (data_done[0]) begin
        n0++;
        if (n0 == 1024) check("t4_wrap", wrap_pulse, 4'b0001);
      end
    end
    check("t4_writes", n0, 1025);
    start_sram = '0;
    repeat (2) tick();

    // master_enable low mid-write: word completes, no new grant until it returns.
    start_sram = 4'b1000; sram_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      master_enable = (i < 1 || i >= 7);
      sram_ack      = (i == 3);
      tick();
    end
    start_sram = '0; master_enable = 1'b1; sram_ack = 1'b1;
    repeat (4) tick();

    // Reset mid-write: outputs drop within the cycle, first grant afterwards goes to ch0.
    start_sram = 4'b0100; sram_ack = 1'b0;
    repeat (2) tick();
    @(posedge wb_clk);
    #2 wb_rst = 1'b1;
    #1;
    check("t6_we", sram_we, 1'b0);
    check("t6_grant", grant, 4'b0000);
    check("t6_done", data_done, 4'b0000);
    model_reset();
    @(negedge wb_clk);
    compare();
    wb_rst = 1'b0;
    start_sram = 4'b1111; sram_ack = 1'b1;
    for (int i = 0; i < N; i++) channel_data[i*DW +: DW] = $urandom();
    tick();
    check("t6_first_grant", grant, 4'b0001);
    check("t6_first_addr", sram_addr, 16'd0);
    tick();
    start_sram = start_sram & ~data_done;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
